// File: rtl/csi_rx_packets_parser_if.sv
// rtl/csi_rx_packets_parser_if.sv - PHY byte-lane and pixel-FIFO bundle for the CSI-2 RX parser
//
// Purpose: groups the D-PHY receive lanes and the downstream pixel FIFO
//          write port into one bundle.
// Signals:
//   phy_data   [31:0] received bytes, lane 0 in [7:0]
//   phy_valid  [3:0]  byte strobes, contiguous from bit 0
//   phy_sot           start-of-transmission pulse
//   fifo_data  [31:0] packed payload word, little-endian
//   fifo_write        pixel FIFO write strobe
//   fifo_last         last payload word of a line
//   fifo_full         pixel FIFO full
// Modports:
//   master - PHY/FIFO environment side
//   slave  - parser side
interface csi_rx_packets_parser_if;
  logic [31:0] phy_data;
  logic [3:0]  phy_valid;
  logic        phy_sot;
  logic [31:0] fifo_data;
  logic        fifo_write;
  logic        fifo_last;
  logic        fifo_full;

  modport master (
    output phy_data, phy_valid, phy_sot, fifo_full,
    input  fifo_data, fifo_write, fifo_last
  );

  modport slave (
    input  phy_data, phy_valid, phy_sot, fifo_full,
    output fifo_data, fifo_write, fifo_last
  );
endinterface

// File: rtl/csi_rx_packets_parser.sv
// rtl/csi_rx_packets_parser.sv - CSI-2 RX packet parser with ECC/CRC checking and payload packing
//
// Purpose: collects 1-4 bytes per cycle from the D-PHY receiver into a byte
//          buffer, parses short (FS/FE) and long packets, checks header ECC
//          and payload CRC, and writes payload as 32-bit words to the pixel FIFO.
// Ports:
//   i_clk          byte clock
//   i_rst_n        asynchronous reset, active low
//   i_enable       parser enable
//   if_bus         PHY lanes in, pixel FIFO out (slave modport)
//   o_frame_start  FS received
//   o_frame_end    FE received
//   o_line_end     accepted pixel line finished
//   o_line_count   lines received in the current frame
//   o_ecc_error    header ECC mismatch
//   o_crc_error    payload CRC mismatch
//   o_wc_error     pixel packet word count differs from line size
//   o_height_error FE with unexpected line count
//   o_overflow     payload discarded because FIFO was full (once per line)
`ifndef LP_RAW10_CODE
`define LP_RAW10_CODE 6'h2B
`endif

module csi_rx_packets_parser #(
  parameter int          LINE_WIDTH     = 640,
  parameter int          BITS_PER_PIXEL = 10,
  parameter int          IMAGE_HEIGHT   = 480,
  parameter logic [5:0]  DATA_TYPE      = `LP_RAW10_CODE
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  csi_rx_packets_parser_if.slave    if_bus,
  output logic                      o_frame_start,
  output logic                      o_frame_end,
  output logic                      o_line_end,
  output logic [11:0]               o_line_count,
  output logic                      o_ecc_error,
  output logic                      o_crc_error,
  output logic                      o_wc_error,
  output logic                      o_height_error,
  output logic                      o_overflow
);

  localparam int BYTES_IN_LINE = LINE_WIDTH * BITS_PER_PIXEL / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOT,
    S_HEADER,
    S_PAYLOAD,
    S_CRC
  } state_t;

  // 6-bit CSI-2 header ECC over the 24 header data bits; top two bits are 0.
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^{d[0], d[1], d[2], d[4], d[5], d[7], d[10], d[11], d[13], d[16], d[20], d[21], d[22], d[23]};
    p[1] = ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10], d[12], d[14], d[17], d[20], d[21], d[22], d[23]};
    p[2] = ^{d[0], d[2], d[3], d[5], d[6], d[9], d[11], d[12], d[15], d[18], d[20], d[21], d[22]};
    p[3] = ^{d[1], d[2], d[3], d[7], d[8], d[9], d[13], d[14], d[15], d[19], d[20], d[21], d[23]};
    p[4] = ^{d[4], d[5], d[6], d[7], d[8], d[9], d[16], d[17], d[18], d[19], d[20], d[22], d[23]};
    p[5] = ^{d[10], d[11], d[12], d[13], d[14], d[15], d[16], d[17], d[18], d[19], d[21], d[22], d[23]};
    return {2'b00, p};
  endfunction

  // CRC-16 x^16+x^12+x^5+1, reflected, bytes taken LSB first; bytes_m1+1 bytes used.
  function automatic logic [15:0] crc_update(input logic [15:0] crc_in,
                                             input logic [31:0] data,
                                             input logic [1:0]  bytes_m1);
    logic [15:0] c;
    c = crc_in;
    for (int b = 0; b < 4; b++) begin
      if (b <= int'(bytes_m1)) begin
        for (int i = 0; i < 8; i++) begin
          if (c[0] ^ data[8*b+i]) c = (c >> 1) ^ 16'h8408;
          else                    c = c >> 1;
        end
      end
    end
    return c;
  endfunction

  state_t        r_state;
  logic [127:0]  r_buf;
  logic [4:0]    r_count;
  logic [15:0]   r_remain;
  logic [15:0]   r_crc;
  logic          r_drop;
  logic          r_ovf_seen;
  logic [31:0]   r_fifo_data;
  logic          r_fifo_write;
  logic          r_fifo_last;
  logic          r_frame_start;
  logic          r_frame_end;
  logic          r_line_end;
  logic [11:0]   r_line_count;
  logic          r_ecc_error;
  logic          r_crc_error;
  logic          r_wc_error;
  logic          r_height_error;
  logic          r_overflow;

  logic [2:0]    w_nin;
  logic [31:0]   w_in_mask;
  logic          w_append;
  logic [2:0]    w_take;
  logic [31:0]   w_take_mask;
  logic [31:0]   w_word;
  logic [4:0]    w_consume;
  logic [4:0]    w_keep;
  logic [127:0]  w_buf_next;
  logic [4:0]    w_count_next;
  logic          w_ecc_ok;

  always_comb begin
    w_nin     = 3'd0;
    w_in_mask = 32'h0;
    case (if_bus.phy_valid)
      4'b0001: begin w_nin = 3'd1; w_in_mask = 32'h0000_00FF; end
      4'b0011: begin w_nin = 3'd2; w_in_mask = 32'h0000_FFFF; end
      4'b0111: begin w_nin = 3'd3; w_in_mask = 32'h00FF_FFFF; end
      4'b1111: begin w_nin = 3'd4; w_in_mask = 32'hFFFF_FFFF; end
      default: begin w_nin = 3'd0; w_in_mask = 32'h0; end
    endcase

    // Bytes are only collected while a burst is being parsed; in IDLE and
    // WAIT_SOT the buffer stays empty so stale bytes cannot form a header.
    w_append = ((r_state == S_HEADER) && i_enable) ||
               (r_state == S_PAYLOAD) || (r_state == S_CRC);

    w_take = (r_remain >= 16'd4) ? 3'd4 : r_remain[2:0];
    case (w_take)
      3'd1:    w_take_mask = 32'h0000_00FF;
      3'd2:    w_take_mask = 32'h0000_FFFF;
      3'd3:    w_take_mask = 32'h00FF_FFFF;
      default: w_take_mask = 32'hFFFF_FFFF;
    endcase
    w_word = r_buf[31:0] & w_take_mask;

    w_consume = 5'd0;
    case (r_state)
      S_HEADER:  if (i_enable && r_count >= 5'd4) w_consume = 5'd4;
      S_PAYLOAD: if (r_count >= {2'b00, w_take}) w_consume = {2'b00, w_take};
      S_CRC:     if (r_count >= 5'd2) w_consume = 5'd2;
      default:   w_consume = 5'd0;
    endcase

    // Shift out consumed bytes and append new ones after the survivors.
    w_keep       = r_count - w_consume;
    w_buf_next   = r_buf >> {w_consume, 3'b000};
    w_count_next = w_keep;
    if (w_append) begin
      w_buf_next   = w_buf_next |
                     ({96'h0, if_bus.phy_data & w_in_mask} << {w_keep, 3'b000});
      w_count_next = w_keep + {2'b00, w_nin};
    end

    w_ecc_ok = (ecc_calc(r_buf[23:0]) == r_buf[31:24]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_buf          <= '0;
      r_count        <= '0;
      r_remain       <= '0;
      r_crc          <= '0;
      r_drop         <= 1'b0;
      r_ovf_seen     <= 1'b0;
      r_fifo_data    <= '0;
      r_fifo_write   <= 1'b0;
      r_fifo_last    <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
      r_line_end     <= 1'b0;
      r_line_count   <= '0;
      r_ecc_error    <= 1'b0;
      r_crc_error    <= 1'b0;
      r_wc_error     <= 1'b0;
      r_height_error <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_fifo_write   <= 1'b0;
      r_fifo_last    <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
      r_line_end     <= 1'b0;
      r_ecc_error    <= 1'b0;
      r_crc_error    <= 1'b0;
      r_wc_error     <= 1'b0;
      r_height_error <= 1'b0;
      r_overflow     <= 1'b0;

      if (if_bus.phy_sot && (r_state != S_IDLE)) begin
        // A new burst always restarts parsing; any partial packet is dropped.
        r_state <= S_HEADER;
        r_buf   <= '0;
        r_count <= '0;
      end else begin
        r_buf   <= w_buf_next;
        r_count <= w_count_next;
        case (r_state)
          S_IDLE: begin
            if (i_enable) r_state <= S_WAIT_SOT;
          end

          S_WAIT_SOT: begin
            if (!i_enable) r_state <= S_IDLE;
          end

          S_HEADER: begin
            if (!i_enable) begin
              r_state <= S_IDLE;
              r_buf   <= '0;
              r_count <= '0;
            end else if (r_count >= 5'd4) begin
              if (!w_ecc_ok) begin
                r_ecc_error <= 1'b1;
                r_state     <= S_WAIT_SOT;
                r_buf       <= '0;
                r_count     <= '0;
              end else if (r_buf[5:0] == 6'h00) begin
                r_frame_start <= 1'b1;
                r_line_count  <= '0;
              end else if (r_buf[5:0] == 6'h01) begin
                r_frame_end <= 1'b1;
                if (r_line_count != 12'(IMAGE_HEIGHT)) r_height_error <= 1'b1;
              end else if (r_buf[5:0] >= 6'h10) begin
                r_remain   <= r_buf[23:8];
                r_crc      <= 16'hFFFF;
                r_drop     <= (r_buf[5:0] != DATA_TYPE);
                r_ovf_seen <= 1'b0;
                if ((r_buf[5:0] == DATA_TYPE) && (r_buf[23:8] != 16'(BYTES_IN_LINE)))
                  r_wc_error <= 1'b1;
                r_state <= (r_buf[23:8] == 16'd0) ? S_CRC : S_PAYLOAD;
              end
            end
          end

          S_PAYLOAD: begin
            if (w_consume != 5'd0) begin
              r_crc    <= crc_update(r_crc, w_word, 2'(w_take - 3'd1));
              r_remain <= r_remain - {13'h0, w_take};
              if (!r_drop) begin
                if (if_bus.fifo_full) begin
                  if (!r_ovf_seen) begin
                    r_overflow <= 1'b1;
                    r_ovf_seen <= 1'b1;
                  end
                end else begin
                  r_fifo_write <= 1'b1;
                  r_fifo_data  <= w_word;
                  r_fifo_last  <= (r_remain == {13'h0, w_take});
                end
              end
              if (r_remain == {13'h0, w_take}) r_state <= S_CRC;
            end
          end

          S_CRC: begin
            if (r_count >= 5'd2) begin
              if (r_buf[15:0] != r_crc) r_crc_error <= 1'b1;
              if (!r_drop) begin
                r_line_end <= 1'b1;
                if (r_line_count != 12'hFFF) r_line_count <= r_line_count + 12'd1;
              end
              r_state <= S_HEADER;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign if_bus.fifo_data  = r_fifo_data;
  assign if_bus.fifo_write = r_fifo_write;
  assign if_bus.fifo_last  = r_fifo_last;
  assign o_frame_start     = r_frame_start;
  assign o_frame_end       = r_frame_end;
  assign o_line_end        = r_line_end;
  assign o_line_count      = r_line_count;
  assign o_ecc_error       = r_ecc_error;
  assign o_crc_error       = r_crc_error;
  assign o_wc_error        = r_wc_error;
  assign o_height_error    = r_height_error;
  assign o_overflow        = r_overflow;

endmodule

// File: tb/tb_csi_rx_packets_parser.sv
// tb/tb_csi_rx_packets_parser.sv - self-checking bench for the CSI-2 RX packet parser
`timescale 1ns/1ps
module tb_csi_rx_packets_parser;
  localparam int         IMG_H  = 2;
  localparam logic [5:0] DT_PIX = 6'h2A;
  // Parity signature of each header data bit: which ECC bits it feeds.
  localparam logic [5:0] ECC_CODE [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
  localparam logic [5:0] DROP_DT [3] = '{6'h12, 6'h2B, 6'h30};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  csi_rx_packets_parser_if bus();
  logic        frame_start, frame_end, line_end;
  logic [11:0] line_count;
  logic        ecc_error, crc_error, wc_error, height_error, overflow;

  csi_rx_packets_parser #(
    .LINE_WIDTH(4), .BITS_PER_PIXEL(8), .IMAGE_HEIGHT(IMG_H), .DATA_TYPE(DT_PIX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .if_bus(bus),
    .o_frame_start(frame_start), .o_frame_end(frame_end), .o_line_end(line_end),
    .o_line_count(line_count), .o_ecc_error(ecc_error), .o_crc_error(crc_error),
    .o_wc_error(wc_error), .o_height_error(height_error), .o_overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  int m_fs = 0, m_fe = 0, m_le = 0, m_ecc = 0, m_crc = 0, m_wc = 0, m_h = 0, m_ovf = 0;
  logic [32:0] m_words[$];
  int e_fs = 0, e_fe = 0, e_le = 0, e_ecc = 0, e_crc = 0, e_wc = 0, e_h = 0, e_ovf = 0;
  int e_lc = 0;
  logic [32:0] e_words[$];
  logic [7:0] pkt[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_write) m_words.push_back({bus.fifo_last, bus.fifo_data});
      if (frame_start)  m_fs++;
      if (frame_end)    m_fe++;
      if (line_end)     m_le++;
      if (ecc_error)    m_ecc++;
      if (crc_error)    m_crc++;
      if (wc_error)     m_wc++;
      if (height_error) m_h++;
      if (overflow)     m_ovf++;
    end
  end

  function automatic logic [7:0] ecc_model(input logic [23:0] h);
    logic [5:0] e;
    e = '0;
    for (int i = 0; i < 24; i++) if (h[i]) e ^= ECC_CODE[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_hdr(input logic [5:0] dt, input logic [15:0] wc);
    logic [23:0] h;
    h = {wc, 2'b00, dt};
    pkt.push_back(h[7:0]);
    pkt.push_back(h[15:8]);
    pkt.push_back(h[23:16]);
    pkt.push_back(ecc_model(h));
  endtask

  task automatic put_long(input logic [5:0] dt, input int wc, input bit rnd);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    put_hdr(dt, 16'(wc));
    for (int i = 0; i < wc; i++) begin
      b = rnd ? 8'($urandom) : 8'(17 * (i + 1));
      pkt.push_back(b);
      c = crc_byte(c, b);
    end
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8]);
  endtask

  // Expected effect of one complete packet held in pkt.
  task automatic model_pkt();
    logic [23:0] h;
    logic [5:0]  dt;
    logic [15:0] c;
    logic [31:0] w;
    int          wc;
    bit          drop;
    bit          got_full;
    h = {pkt[2], pkt[1], pkt[0]};
    if (ecc_model(h) != pkt[3]) begin
      e_ecc++;
      return;
    end
    dt = h[5:0];
    if (dt == 6'h00) begin
      e_fs++;
      e_lc = 0;
    end else if (dt == 6'h01) begin
      e_fe++;
      if (e_lc != IMG_H) e_h++;
    end else if (dt >= 6'h10) begin
      drop = (dt != DT_PIX);
      got_full = 1'b0;
      wc = int'(h[23:8]);
      if (!drop && wc != 4) e_wc++;
      c = 16'hFFFF;
      for (int i = 0; i < wc; i += 4) begin
        w = '0;
        for (int j = 0; j < 4 && i + j < wc; j++) begin
          w[8*j +: 8] = pkt[4+i+j];
          c = crc_byte(c, pkt[4+i+j]);
        end
        if (!drop) begin
          if (bus.fifo_full) got_full = 1'b1;
          else e_words.push_back({(i + 4 >= wc), w});
        end
      end
      if (got_full) e_ovf++;
      if ({pkt[5+wc], pkt[4+wc]} != c) e_crc++;
      if (!drop) begin
        e_le++;
        if (e_lc < 4095) e_lc++;
      end
    end
  endtask

  task automatic send(input int lanes, input int gap_pct);
    int i;
    int k;
    i = 0;
    @(posedge clk); #1;
    bus.phy_sot = 1'b1;
    bus.phy_valid = 4'h0;
    @(posedge clk); #1;
    bus.phy_sot = 1'b0;
    while (i < pkt.size()) begin
      bus.phy_data = $urandom;
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        bus.phy_valid = 4'h0;
      end else begin
        k = (pkt.size() - i < lanes) ? pkt.size() - i : lanes;
        for (int j = 0; j < k; j++) bus.phy_data[8*j +: 8] = pkt[i+j];
        bus.phy_valid = 4'((1 << k) - 1);
        i += k;
      end
      @(posedge clk); #1;
    end
    bus.phy_valid = 4'h0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_m(input int lanes, input int gap_pct);
    model_pkt();
    send(lanes, gap_pct);
  endtask

  task automatic short_pkt(input logic [5:0] dt, input int lanes, input int gap_pct);
    pkt.delete();
    put_hdr(dt, 16'($urandom));
    send_m(lanes, gap_pct);
  endtask

  task automatic pix_line(input int lanes, input int gap_pct, input bit rnd);
    pkt.delete();
    put_long(DT_PIX, 4, rnd);
    send_m(lanes, gap_pct);
  endtask

  task automatic frame(input int lanes, input int gap_pct, input int nlines);
    short_pkt(6'h00, lanes, gap_pct);
    for (int n = 0; n < nlines; n++) pix_line(lanes, gap_pct, 1'b0);
    short_pkt(6'h01, lanes, gap_pct);
  endtask

  task automatic clear_all();
    m_fs = 0; m_fe = 0; m_le = 0; m_ecc = 0; m_crc = 0; m_wc = 0; m_h = 0; m_ovf = 0;
    e_fs = 0; e_fe = 0; e_le = 0; e_ecc = 0; e_crc = 0; e_wc = 0; e_h = 0; e_ovf = 0;
    m_words.delete();
    e_words.delete();
  endtask

  task automatic check_scn(input string s);
    chk({s, " frame_start"}, m_fs, e_fs);
    chk({s, " frame_end"}, m_fe, e_fe);
    chk({s, " line_end"}, m_le, e_le);
    chk({s, " ecc_error"}, m_ecc, e_ecc);
    chk({s, " crc_error"}, m_crc, e_crc);
    chk({s, " wc_error"}, m_wc, e_wc);
    chk({s, " height_error"}, m_h, e_h);
    chk({s, " overflow"}, m_ovf, e_ovf);
    chk({s, " word_count"}, m_words.size(), e_words.size());
    for (int i = 0; i < e_words.size() && i < m_words.size(); i++)
      chk({s, " word"}, m_words[i], e_words[i]);
    chk({s, " line_count"}, line_count, e_lc);
  endtask

  initial begin
    bus.phy_data  = '0;
    bus.phy_valid = '0;
    bus.phy_sot   = 1'b0;
    bus.fifo_full = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset outputs",
        {bus.fifo_data, bus.fifo_write, bus.fifo_last, frame_start, frame_end, line_end,
         line_count, ecc_error, crc_error, wc_error, height_error, overflow}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    clear_all();
    frame(4, 0, 2);
    check_scn("s1 4-lane");
    chk("s1 word0 literal", m_words[0], {1'b1, 32'h44332211});
    chk("s1 line_count literal", line_count, 12'd2);

    for (int lanes = 1; lanes <= 3; lanes++) begin
      clear_all();
      frame(lanes, 30, 2);
      check_scn($sformatf("s2 %0d-lane", lanes));
    end

    clear_all();
    pkt.delete();
    put_long(DT_PIX, 4, 1'b0);
    pkt[3] = pkt[3] ^ 8'(1 << $urandom_range(0, 7));
    send_m(4, 0);
    short_pkt(6'h00, 4, 0);
    check_scn("s3 ecc");

    clear_all();
    short_pkt(6'h00, 2, 10);
    pkt.delete();
    put_long(DT_PIX, 4, 1'b1);
    pkt[4 + $urandom_range(0, 3)] ^= 8'($urandom_range(1, 255));
    send_m(2, 10);
    pix_line(4, 10, 1'b1);
    short_pkt(6'h01, 4, 10);
    check_scn("s4 crc");

    clear_all();
    short_pkt(6'h00, 4, 0);
    pkt.delete();
    put_long(DT_PIX, 6, 1'b0);
    send_m(3, 20);
    pkt.delete();
    put_long(DT_PIX, 0, 1'b0);
    send_m(4, 0);
    check_scn("s5 wc");
    chk("s5 word0 literal", m_words[0], {1'b0, 32'h44332211});
    chk("s5 word1 literal", m_words[1], {1'b1, 32'h00006655});

    clear_all();
    short_pkt(6'h00, 4, 0);
    bus.fifo_full = 1'b1;
    pix_line(4, 0, 1'b1);
    bus.fifo_full = 1'b0;
    check_scn("s6 overflow");

    clear_all();
    short_pkt(6'h00, 4, 0);
    pkt.delete();
    put_long(DT_PIX, 4, 1'b1);
    while (pkt.size() > 6) void'(pkt.pop_back());
    send(1, 0);
    pix_line(4, 0, 1'b1);
    pix_line(4, 0, 1'b1);
    short_pkt(6'h01, 4, 0);
    check_scn("s6 sot mid-payload");

    clear_all();
    frame(4, 0, 1);
    check_scn("s6 height");

    for (int it = 0; it < 3; it++) begin
      clear_all();
      short_pkt(6'h00, $urandom_range(1, 4), 20);
      for (int p = 0; p < 4; p++) begin
        pkt.delete();
        case ($urandom_range(0, 2))
          0: put_long(DT_PIX, 4, 1'b1);
          1: put_long(DROP_DT[$urandom_range(0, 2)], $urandom_range(0, 7), 1'b1);
          default: put_hdr(6'($urandom_range(2, 15)), 16'($urandom));
        endcase
        send_m($urandom_range(1, 4), 20);
      end
      short_pkt(6'h01, $urandom_range(1, 4), 20);
      check_scn($sformatf("s7 random %0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
